// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag layout and controller state encoding shared by the ALU and its execute controller
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_NOT,
        OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR, OP_MOV
    } op_t;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;
    function automatic logic upd_v(input logic [3:0] op);
        return op <= OP_SBC;
    endfunction
    function automatic logic upd_c(input logic [3:0] op);
        return op <= OP_SBC || (op >= OP_LSL && op <= OP_ROR);
    endfunction
endpackage

// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: instruction, completion and ALU buses around the execute controller
interface alu_exec_ctrl_if #(parameter int DW = 16);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_instr;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [4:0]    alu_op;
    logic          alu_cin;
    logic [DW-1:0] alu_y;
    logic          alu_z;
    logic          alu_n;
    logic          alu_c;
    logic          alu_v;
    logic          done_valid;
    logic          done_ready;
    logic [DW-1:0] done_result;
    logic          done_err;
    modport master (
        output in_valid, in_instr, done_ready, alu_y, alu_z, alu_n, alu_c, alu_v,
        input  in_ready, alu_a, alu_b, alu_op, alu_cin, done_valid, done_result, done_err
    );
    modport slave (
        input  in_valid, in_instr, done_ready, alu_y, alu_z, alu_n, alu_c, alu_v,
        output in_ready, alu_a, alu_b, alu_op, alu_cin, done_valid, done_result, done_err
    );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: general register file, one synchronous write port, two operand reads and a debug read
module alu_regfile #(
    parameter int NREGS = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    logic [DW-1:0] mem [NREGS];

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

    // Single write port; all registers clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: three-state execute controller that sequences an external combinational ALU
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_ctrl_if.slave bus,
    input  logic           ld_en,
    input  logic [3:0]     ld_addr,
    input  logic [DW-1:0]  ld_data,
    input  logic [3:0]     dbg_addr,
    output logic [DW-1:0]  dbg_data,
    output logic [3:0]     flags
);
    logic [1:0]    state;
    logic [3:0]    op;
    logic [3:0]    dest;
    logic [DW-1:0] ra, rb, res, rd_a, rd_b, exec_y;
    logic          err, in_idle, in_exec, in_done, illegal, is_mov;
    nzcv_t         fl, nzcv;

    assign in_idle = state == ST_IDLE;
    assign in_exec = state == ST_EXEC;
    assign in_done = state == ST_DONE;
    assign illegal = bus.in_instr[15:12] > OP_MOV;
    assign is_mov  = op == OP_MOV;
    assign flags   = fl;

    assign bus.in_ready    = in_idle && !ld_en;
    assign bus.alu_a       = in_exec ? ra : '0;
    assign bus.alu_b       = in_exec ? rb : '0;
    assign bus.alu_op      = in_exec && !is_mov ? {1'b0, op} : '0;
    assign bus.alu_cin     = in_exec && fl.c;
    assign bus.done_valid  = in_done;
    assign bus.done_err    = in_done && err;
    assign bus.done_result = in_done ? res : '0;

    // MOV bypasses the ALU, so its N/Z come straight from the source operand
    assign exec_y = is_mov ? rb : bus.alu_y;
    assign nzcv   = '{n: is_mov ? rb[DW-1] : bus.alu_n,
                      z: is_mov ? rb == '0 : bus.alu_z,
                      c: upd_c(op) ? bus.alu_c : fl.c,
                      v: upd_v(op) ? bus.alu_v : fl.v};

    alu_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (in_exec || (in_idle && ld_en)),
        .waddr    (in_exec ? dest : ld_addr),
        .wdata    (in_exec ? exec_y : ld_data),
        .raddr_a  (bus.in_instr[11:8]),
        .rdata_a  (rd_a),
        .raddr_b  (bus.in_instr[7:4]),
        .rdata_b  (rd_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Accept and latch operands in IDLE, capture ALU result in EXEC, hold DONE until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op    <= '0;
            dest  <= '0;
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            err   <= 1'b0;
            fl    <= '0;
        end else if (in_idle) begin
            if (bus.in_valid && bus.in_ready) begin
                op    <= bus.in_instr[15:12];
                dest  <= bus.in_instr[11:8];
                ra    <= rd_a;
                rb    <= rd_b;
                res   <= '0;
                err   <= illegal;
                state <= illegal ? ST_DONE : ST_EXEC;
            end
        end else if (in_exec) begin
            res   <= exec_y;
            fl    <= nzcv;
            state <= ST_DONE;
        end else if (bus.done_ready) begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: table-driven instruction sequence with a completion scoreboard plus corner-case sequences
module tb_alu_exec_ctrl;
    typedef struct {
        logic [15:0] instr;
        logic [15:0] res;
        logic        err;
        logic [3:0]  nzcv;
    } vec_t;
    typedef struct {
        logic [15:0] res;
        logic        err;
        logic [3:0]  nzcv;
        logic [3:0]  dest;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        ld_en = 0;
    logic [3:0]  ld_addr = 0;
    logic [15:0] ld_data = 0;
    logic [3:0]  dbg_addr = 0;
    logic [15:0] dbg_data;
    logic [3:0]  flags;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    vec_t        tbl[17];

    alu_exec_ctrl_if #(.DW(16)) bus();

    alu_exec_ctrl #(.NREGS(16), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    // Reference 16-bit ALU: shifts/rotates by one, carry = not-borrow on subtract
    function automatic logic [19:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] bb, y;
        logic        c, v;
        bb = (op == 5'd2 || op == 5'd3) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + (op == 5'd1 || op == 5'd3 ? {16'd0, cin} : op == 5'd2 ? 17'd1 : 17'd0);
        y  = s[15:0];
        c  = 1'b0;
        v  = 1'b0;
        if (op <= 5'd3) begin
            c = s[16];
            v = (a[15] == bb[15]) && (y[15] != a[15]);
        end
        case (op)
            5'd4:  y = a & b;
            5'd5:  y = a | b;
            5'd6:  y = a ^ b;
            5'd7:  y = ~a;
            5'd8:  begin y = {a[14:0], 1'b0};   c = a[15]; end
            5'd9:  begin y = {1'b0, a[15:1]};   c = a[0];  end
            5'd10: begin y = {a[15], a[15:1]};  c = a[0];  end
            5'd11: begin y = {a[14:0], a[15]};  c = a[15]; end
            5'd12: begin y = {a[0], a[15:1]};   c = a[0];  end
            default: ;
        endcase
        return {y, y[15], y == 16'd0, c, v};
    endfunction

    always_comb {bus.alu_y, bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 0;
    endtask

    task automatic issue(input logic [15:0] instr, input logic [15:0] res, input logic err, input logic [3:0] nzcv);
        int n = 0;
        @(negedge clk);
        bus.in_instr = instr;
        bus.in_valid = 1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", bus.in_ready, 1);
        @(posedge clk);
        sb.push_back('{res, err, nzcv, instr[11:8]});
        #1 bus.in_valid = 0;
    endtask

    task automatic finish(input logic [15:0] instr, input int hold);
        int   n = 1;
        exp_t e;
        bus.done_ready = (hold == 0);
        @(negedge clk);
        while (!bus.done_valid && n < 20) begin
            if (n == 1) check("alu_op", bus.alu_op, instr[15:12] == 4'd13 ? 0 : {1'b0, instr[15:12]});
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check("latency", n, e.err ? 1 : 2);
        check("done_result", bus.done_result, e.res);
        check("done_err", bus.done_err, e.err);
        check("flags", flags, e.nzcv);
        if (!e.err) begin
            dbg_addr = e.dest;
            #1 check("writeback", dbg_data, e.res);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.done_valid, 1);
            check("hold_err", bus.done_err, e.err);
            check("hold_result", bus.done_result, e.res);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.done_ready = 1;
        @(posedge clk);
        #1 check("released", bus.done_valid, 0);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_instr = 0;
        bus.done_ready = 1;
        tbl[0]  = '{16'h0120, 16'h8000, 1'b0, 4'b1001};
        tbl[1]  = '{16'h0890, 16'h0000, 1'b0, 4'b0110};
        tbl[2]  = '{16'h3340, 16'h0000, 1'b0, 4'b0110};
        tbl[3]  = '{16'h4560, 16'h0000, 1'b0, 4'b0110};
        tbl[4]  = '{16'hC700, 16'h8000, 1'b0, 4'b1010};
        tbl[5]  = '{16'hDA10, 16'h8000, 1'b0, 4'b1010};
        tbl[6]  = '{16'h2220, 16'h0000, 1'b0, 4'b0110};
        tbl[7]  = '{16'h1990, 16'h0003, 1'b0, 4'b0000};
        tbl[8]  = '{16'h8100, 16'h0000, 1'b0, 4'b0110};
        tbl[9]  = '{16'h6640, 16'h0F05, 1'b0, 4'b0010};
        tbl[10] = '{16'h7400, 16'hFFFA, 1'b0, 4'b1010};
        tbl[11] = '{16'hA400, 16'hFFFD, 1'b0, 4'b1000};
        tbl[12] = '{16'h9400, 16'h7FFE, 1'b0, 4'b0010};
        tbl[13] = '{16'h5560, 16'h0F05, 1'b0, 4'b0010};
        tbl[14] = '{16'hB400, 16'hFFFC, 1'b0, 4'b1000};
        tbl[15] = '{16'hE123, 16'h0000, 1'b1, 4'b1000};
        tbl[16] = '{16'hF000, 16'h0000, 1'b1, 4'b1000};

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_done_valid", bus.done_valid, 0);
        check("rst_done_err", bus.done_err, 0);
        check("rst_done_result", bus.done_result, 0);
        check("rst_flags", flags, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_alu_cin", bus.alu_cin, 0);
        rst_n = 1;

        preload(4'd1, 16'h7FFF);
        preload(4'd2, 16'h0001);
        preload(4'd3, 16'h0005);
        preload(4'd4, 16'h0005);
        preload(4'd5, 16'h00F0);
        preload(4'd6, 16'h0F00);
        preload(4'd7, 16'h0001);
        preload(4'd8, 16'hFFFF);
        preload(4'd9, 16'h0001);
        for (int i = 0; i < 17; i++) begin
            issue(tbl[i].instr, tbl[i].res, tbl[i].err, tbl[i].nzcv);
            finish(tbl[i].instr, 0);
        end

        issue(16'hE000, 16'h0000, 1'b1, 4'b1000);
        finish(16'hE000, 5);
        dbg_addr = 0;
        #1 check("err_no_write", dbg_data, 0);
        check("err_flags_kept", flags, 4'b1000);

        @(negedge clk);
        bus.in_instr = 16'h2120;
        bus.in_valid = 1;
        @(posedge clk);
        #1 bus.in_valid = 0;
        @(negedge clk);
        check("abort_exec_op", bus.alu_op, 2);
        rst_n = 0;
        #1 check("abort_in_ready", bus.in_ready, 1);
        check("abort_alu_op", bus.alu_op, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", bus.done_valid, 0);
        end
        check("abort_flags", flags, 0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1 check("abort_reg_clear", dbg_data, 0);
        end

        @(negedge clk);
        ld_en = 1;
        ld_addr = 4'd3;
        ld_data = 16'h1234;
        bus.in_instr = 16'h0330;
        bus.in_valid = 1;
        #1 check("ld_blocks_ready", bus.in_ready, 0);
        @(negedge clk);
        ld_en = 0;
        dbg_addr = 4'd3;
        #1 check("preload_seen", dbg_data, 16'h1234);
        check("ready_after_ld", bus.in_ready, 1);
        @(posedge clk);
        sb.push_back('{16'h2468, 1'b0, 4'b0000, 4'd3});
        #1 bus.in_valid = 0;
        finish(16'h0330, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
